// File: rtl/r2n_buffer_if.sv
// Block-in / row-out handshake bundle for the row-block to row-major buffer.
// master drives blocks and consumes rows; slave is the buffer side.
interface r2n_buffer_if #(
   parameter int WIDTH      = 16,
   parameter int ROW        = 256,
   parameter int COL        = 64,
   parameter int BLOCK_SIZE = 2,
   parameter int CHUNK_SIZE = 4
);
   localparam int BW = WIDTH * BLOCK_SIZE * CHUNK_SIZE;
   localparam int IW = $clog2(ROW);

   logic                   in_valid;
   logic                   in_ready;
   logic [BW-1:0]          in_block;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH*COL-1:0]   out_row;
   logic [IW-1:0]          out_row_idx;
   logic                   out_last;

   modport master (
      output in_valid, in_block, out_ready,
      input  in_ready, out_valid, out_row, out_row_idx, out_last
   );

   modport slave (
      input  in_valid, in_block, out_ready,
      output in_ready, out_valid, out_row, out_row_idx, out_last
   );
endinterface

// File: rtl/r2n_buffer.sv
// Reassembles BLOCK_SIZE x CHUNK_SIZE tiles into full matrix rows using
// two ping-pong strip banks, one being filled while the other drains.
module r2n_buffer #(
   parameter int WIDTH      = 16,
   parameter int ROW        = 256,
   parameter int COL        = 64,
   parameter int BLOCK_SIZE = 2,
   parameter int CHUNK_SIZE = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   output logic           done,
   r2n_buffer_if.slave    bus
);
   localparam int NCB = COL / CHUNK_SIZE;
   localparam int NST = ROW / BLOCK_SIZE;
   localparam int CBW = (NCB > 1) ? $clog2(NCB) : 1;
   localparam int STW = $clog2(NST + 1);
   localparam int RRW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam int IW  = $clog2(ROW);
   localparam int CW  = (COL > 1) ? $clog2(COL) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [CBW-1:0]   colblk_q, colblk_d;
   logic [STW-1:0]   strip_q, strip_d;
   logic [RRW-1:0]   rd_row_q, rd_row_d;
   logic [IW-1:0]    rd_idx_q, rd_idx_d;
   logic [1:0]       full_q, full_d;

   logic [WIDTH-1:0] mem_q [2][BLOCK_SIZE][COL];

   logic             run;
   logic             acc;
   logic             cons;
   logic             last_cb;
   logic             last_row;
   logic             last_idx;
   logic [WIDTH*COL-1:0] row_w;

   assign run      = (state_q == RUN);
   assign last_cb  = (colblk_q == CBW'(NCB - 1));
   assign last_row = (rd_row_q == RRW'(BLOCK_SIZE - 1));
   assign last_idx = (rd_idx_q == IW'(ROW - 1));

   assign bus.in_ready    = run && !full_q[wr_bank_q]
                          && (strip_q < STW'(NST));
   assign bus.out_valid   = run && full_q[rd_bank_q];
   assign bus.out_row_idx = rd_idx_q;
   assign bus.out_last    = bus.out_valid && last_idx;
   assign bus.out_row     = row_w;
   assign done            = (state_q == DONE);

   assign acc  = bus.in_valid && bus.in_ready;
   assign cons = bus.out_valid && bus.out_ready;

   always_comb begin
      state_d   = state_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      colblk_d  = colblk_q;
      strip_d   = strip_q;
      rd_row_d  = rd_row_q;
      rd_idx_d  = rd_idx_q;
      full_d    = full_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = RUN;
               wr_bank_d = 1'b0;
               rd_bank_d = 1'b0;
               colblk_d  = '0;
               strip_d   = '0;
               rd_row_d  = '0;
               rd_idx_d  = '0;
               full_d    = '0;
            end
         end
         RUN: begin
            // Fill and drain always target different banks, so both apply.
            if (acc) begin
               colblk_d = colblk_q + 1'b1;
               if (last_cb) begin
                  full_d[wr_bank_q] = 1'b1;
                  colblk_d          = '0;
                  wr_bank_d         = ~wr_bank_q;
                  strip_d           = strip_q + 1'b1;
               end
            end
            if (cons) begin
               rd_row_d = rd_row_q + 1'b1;
               rd_idx_d = rd_idx_q + 1'b1;
               if (last_row) begin
                  full_d[rd_bank_q] = 1'b0;
                  rd_row_d          = '0;
                  rd_bank_d         = ~rd_bank_q;
               end
               if (last_idx) state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         colblk_q  <= '0;
         strip_q   <= '0;
         rd_row_q  <= '0;
         rd_idx_q  <= '0;
         full_q    <= '0;
      end else begin
         state_q   <= state_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         colblk_q  <= colblk_d;
         strip_q   <= strip_d;
         rd_row_q  <= rd_row_d;
         rd_idx_q  <= rd_idx_d;
         full_q    <= full_d;
      end
   end

   always_ff @(posedge clk) begin
      if (acc) begin
         for (int r = 0; r < BLOCK_SIZE; r++) begin
            for (int c = 0; c < CHUNK_SIZE; c++) begin
               mem_q[wr_bank_q][RRW'(r)][CW'(int'(colblk_q) * CHUNK_SIZE + c)]
                  <= bus.in_block[(r*CHUNK_SIZE+c)*WIDTH +: WIDTH];
            end
         end
      end
   end

   always_comb begin
      row_w = '0;
      for (int c = 0; c < COL; c++) begin
         row_w[WIDTH*COL-1-c*WIDTH -: WIDTH] = mem_q[rd_bank_q][rd_row_q][CW'(c)];
      end
   end
endmodule

// File: doc/r2n_buffer.md
R2N_BUFFER -- requirements
Module: r2n_buffer

Interface
REQ-001 Parameter WIDTH, default 16: bits per fixed-point element.
REQ-002 Parameter ROW, default 256: matrix rows, SHALL be a multiple of BLOCK_SIZE.
REQ-003 Parameter COL, default 64: matrix columns, SHALL be a multiple of CHUNK_SIZE.
REQ-004 Parameter BLOCK_SIZE, default 2: rows per incoming block.
REQ-005 Parameter CHUNK_SIZE, default 4: columns per incoming block.
REQ-006 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Port start, input, 1: one-cycle pulse that begins a matrix transfer.
REQ-009 Port in_valid, input, 1: in_block holds a valid block.
REQ-010 Port in_ready, output, 1: block accepted on a cycle where in_valid && in_ready.
REQ-011 Port in_block, input, WIDTH*BLOCK_SIZE*CHUNK_SIZE: element (r,c) at bit offset (r*CHUNK_SIZE+c)*WIDTH.
REQ-012 Port out_valid, output, 1: out_row holds a valid row.
REQ-013 Port out_ready, input, 1: row consumed on a cycle where out_valid && out_ready.
REQ-014 Port out_row, output, WIDTH*COL: row-major; column c at [WIDTH*COL-1-c*WIDTH -: WIDTH].
REQ-015 Port out_row_idx, output, $clog2(ROW): matrix row index of out_row.
REQ-016 Port out_last, output, 1: high with out_valid when out_row_idx == ROW-1.
REQ-017 Port done, output, 1: level, high while in DONE.

Function
REQ-018 Blocks SHALL arrive row-block-major: column-block index 0..COL/CHUNK_SIZE-1 inner, row-block index 0..ROW/BLOCK_SIZE-1 outer.
REQ-019 Storage SHALL be two strip banks, each BLOCK_SIZE rows x COL columns of registers, with a full flag per bank.
REQ-020 FSM states: IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE when the row with out_row_idx == ROW-1 is consumed; DONE->RUN on start; start in RUN SHALL be ignored.
REQ-021 On entry to RUN: write bank, read bank, column-block count, strip count, row-in-strip count and both full flags SHALL clear to 0.
REQ-022 in_ready SHALL be 1 only in RUN, with the write bank not full, and fewer than ROW/BLOCK_SIZE strips accepted.
REQ-023 An accepted block SHALL be written at columns colblk*CHUNK_SIZE..+CHUNK_SIZE-1 of the write bank; colblk then increments.
REQ-024 Acceptance of the last column block of a strip SHALL set that bank's full flag, wrap colblk to 0, toggle the write bank and increment the strip count.
REQ-025 out_valid SHALL equal (state == RUN) && full flag of read bank; out_valid rises one cycle after the strip's last block is accepted.
REQ-026 out_row SHALL be read from the registers of read bank row rd_row; out_row and out_row_idx SHALL be stable while out_valid && !out_ready.
REQ-027 A consumed row SHALL increment rd_row; consumption of row BLOCK_SIZE-1 SHALL clear the read bank's full flag, wrap rd_row to 0 and toggle the read bank.
REQ-028 A block accept into one bank and a row consume from the other bank in the same cycle SHALL both take effect.
REQ-029 A full flag cleared by consumption SHALL allow in_ready on the next cycle (no same-cycle bypass).
REQ-030 Data SHALL pass unmodified; no arithmetic is performed on elements.

Reset
REQ-031 While rst is high: state = IDLE; in_ready, out_valid, out_last, done = 0; out_row_idx = 0; all counters and full flags = 0.
REQ-032 rst asserted mid-transfer SHALL discard all buffered data; a new start is required before any transfer.
REQ-033 Bank data registers need not be reset.

Verification (WIDTH=8, ROW=4, COL=8, BLOCK_SIZE=2, CHUNK_SIZE=4)
REQ-034 start, then 4 blocks with out_ready=1, element value = 16*row+col -> rows 0..3 emitted in order, row r column c = 16*r+c, out_last on row 3, done the next cycle.
REQ-035 out_ready=0 throughout, in_valid=1 -> 4 blocks accepted (both banks filled), in_ready then 0; out_valid=1 with out_row_idx=0 held stable.
REQ-036 Continuous in_valid and out_ready -> an accept and a consume coincide in at least one cycle; no block or row is lost or duplicated.
REQ-037 rst pulsed after 3 blocks accepted -> out_valid=0, in_ready=0, state IDLE; a restart then yields a correct full matrix.
REQ-038 start pulsed during RUN -> ignored; output identical to REQ-034.
REQ-039 in_valid toggled randomly, out_ready toggled randomly, 3 back-to-back matrices each started from DONE -> every row matches the golden row-major model.
